fft_frame_streamer: RTL
=======================

Name: fft_frame_streamer

Overview:
- Buffers complete 512-bin FFT output frames from the FFT core's unload port into a two-bank (ping-pong) RAM.
- Replays each stored frame to the note-detection FSM over the fft_done / fft_address / fft_read_valid / data_in_real / data_in_imag interface, one bin per clock, bins 0..511 in order.
- After each replay it waits for the consumer's note_done before releasing that bank, so one frame can be captured while the previous one is analysed.

Parameters:
- ADDR_W, 9, bin index width; frame length is 2**ADDR_W bins.
- DATA_W, 18, width of each real and imaginary component.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  FFT unload data valid
- in_index  in  ADDR_W  bin index of the current input sample
- in_real  in  DATA_W  real part of the input bin
- in_imag  in  DATA_W  imaginary part of the input bin
- note_done  in  1  consumer acknowledge that frame analysis is finished
- fft_done  out  1  high for the whole frame replay
- fft_read_valid  out  1  high while data_in_real / data_in_imag are valid
- fft_address  out  ADDR_W  bin index of the data currently presented
- data_in_real  out  DATA_W  replayed real part
- data_in_imag  out  DATA_W  replayed imaginary part
- frame_dropped  out  1  one-cycle pulse when an input frame is discarded
- busy  out  1  high when either bank holds a frame or a replay is in progress

Behaviour:
- Reset: all outputs 0; both bank-full flags 0; write bank 0; read bank 0; FSM in IDLE. RAM contents are not cleared.
- Capture:
  - in_valid writes {in_real, in_imag} to mem[wbank][in_index], but only when wbank is not full.
  - in_index==0 with in_valid restarts the current frame (overwrite); partial frames are never committed.
  - in_valid with in_index==2**ADDR_W-1 commits the frame: full[wbank]<=1 and wbank toggles.
  - Input arriving while full[wbank]==1 (both banks full) is discarded. frame_dropped pulses on the cycle the discarded sample has index 2**ADDR_W-1.
- Readout FSM states: IDLE, PRIME, STREAM, WAIT_ACK.
  - IDLE: when full[rbank]==1, go to PRIME and issue RAM read of addr 0.
  - PRIME: 1 cycle (covers the registered RAM read latency); issue addr 1; go to STREAM.
  - STREAM: fft_done=1, fft_read_valid=1, fft_address=k, data = bin k of rbank, for k=0..511 on consecutive cycles with no gaps. On the cycle after k=511 go to WAIT_ACK.
  - WAIT_ACK: fft_done=0, fft_read_valid=0, fft_address=0, data holds its last value. note_done high (level or pulse) clears full[rbank], toggles rbank, and returns to IDLE.
  - note_done in any state other than WAIT_ACK is ignored.
- Latency:
  - Commit of index 511 at edge t (bank otherwise idle) -> fft_done high from edge t+2, for exactly 512 cycles.
  - Back-to-back stored frame: the next replay starts 2 cycles after the edge that samples note_done.
- Simultaneous events:
  - note_done release and a commit into the other bank on the same cycle: both take effect; full flags update independently.
  - Commit and release of the same bank cannot coincide, because only empty banks are written.
- Reset asserted mid-capture or mid-replay: immediately returns to the reset state. The in-flight frame is lost and outputs go to 0 asynchronously.
- busy = full[0] | full[1] | (state != IDLE).

Test Plan:
- Reset, then frame A with bin k = {real=k, imag=511-k}, indices 0..511 in order, in_valid continuous -> fft_done rises 2 cycles after index 511 is written; over 512 cycles fft_address=k with data_in_real=k and data_in_imag=511-k; then fft_done=0 and fft_address=0.
- Frames A and B back-to-back, note_done pulsed 20 cycles after replay A ends -> B captured during A's WAIT_ACK; B replay starts exactly 2 cycles after note_done is sampled; frame_dropped never pulses.
- Frames A, B, C with no note_done -> A replayed, B held, C discarded; frame_dropped pulses once, on C's index 511; asserting note_done then replays B, not C.
- Frame aborted at index 200, then restarted from index 0 with values +1000 -> replay contains only the restarted values; no replay is triggered at the abort.
- reset_n pulled low at replay bin 300 -> all outputs 0 at once; after release busy=0; a fresh frame replays correctly from bin 0.
- note_done held high through STREAM -> ignored until WAIT_ACK; the bank is released on the first WAIT_ACK cycle.

Source files
------------

// File: rtl/fft_frame_streamer.sv
// fft_frame_streamer: captures complete FFT frames into a ping-pong RAM and
// replays each stored frame, one bin per clock, to the note-detection FSM.
// A bank is released only after the consumer acknowledges with note_done.
module fft_frame_streamer #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 18
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_index,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  input  logic              note_done,
  output logic              fft_done,
  output logic              fft_read_valid,
  output logic [ADDR_W-1:0] fft_address,
  output logic [DATA_W-1:0] data_in_real,
  output logic [DATA_W-1:0] data_in_imag,
  output logic              frame_dropped,
  output logic              busy
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_BIN = '1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PRIME    = 2'd1;
  localparam logic [1:0] S_STREAM   = 2'd2;
  localparam logic [1:0] S_WAIT_ACK = 2'd3;

  // Bank select is the MSB of the RAM address: {bank, bin}.
  logic [2*DATA_W-1:0] mem [0:2*DEPTH-1];

  logic [1:0]          full;
  logic                wbank;
  logic                rbank;
  logic [1:0]          state;
  logic [ADDR_W-1:0]   raddr;
  logic [ADDR_W-1:0]   bin_cnt;
  logic [2*DATA_W-1:0] rdata;

  logic accept;
  logic commit;
  logic release_bank;
  logic rd_en;

  // Samples are only taken into a bank that holds no committed frame.
  assign accept       = in_valid & ~full[wbank];
  assign commit       = accept & (in_index == LAST_BIN);
  assign release_bank = (state == S_WAIT_ACK) & note_done;
  // Read one bin ahead of the presented bin; stop after the last one so the
  // data outputs hold the final bin through WAIT_ACK.
  assign rd_en        = (state == S_PRIME) |
                        ((state == S_STREAM) & (bin_cnt != LAST_BIN));

  // RAM write port; index 0 simply overwrites, which restarts a frame.
  // NOTE: the RAM array is deliberately not reset -- clearing it would need a
  // per-word write sweep and every bin is rewritten before it can be replayed.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[{wbank, in_index}] <= {in_real, in_imag};
    end
  end

  // Registered RAM read port feeding the replay data outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[{rbank, raddr}];
    end
  end

  // Bank-full flags and write-bank pointer; commit and release act on
  // different banks so both may happen in the same cycle.
  // NOTE: all clocked state uses non-blocking assignments so every block sees
  // pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full  <= 2'b00;
      wbank <= 1'b0;
    end else begin
      if (commit) begin
        full[wbank] <= 1'b1;
        wbank       <= ~wbank;
      end
      if (release_bank) begin
        full[rbank] <= 1'b0;
      end
    end
  end

  // Readout FSM: prime the RAM pipeline, stream all bins, wait for the ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      rbank   <= 1'b0;
      raddr   <= '0;
      bin_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (full[rbank]) begin
            raddr <= '0;
            state <= S_PRIME;
          end
        end
        S_PRIME: begin
          raddr   <= raddr + 1'b1;
          bin_cnt <= '0;
          state   <= S_STREAM;
        end
        S_STREAM: begin
          raddr   <= raddr + 1'b1;
          bin_cnt <= bin_cnt + 1'b1;
          if (bin_cnt == LAST_BIN) begin
            state <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (note_done) begin
            rbank <= ~rbank;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign fft_done       = (state == S_STREAM);
  assign fft_read_valid = (state == S_STREAM);
  assign fft_address    = (state == S_STREAM) ? bin_cnt : '0;
  assign data_in_real   = rdata[2*DATA_W-1:DATA_W];
  assign data_in_imag   = rdata[DATA_W-1:0];
  assign frame_dropped  = in_valid & full[wbank] & (in_index == LAST_BIN);
  assign busy           = full[0] | full[1] | (state != S_IDLE);

endmodule
